// File: rtl/reg_file_sb.sv
// Register file with a pending-writeback scoreboard and combinational reads.
// It has two read ports, write-through bypass, an optional hard-zero r0 and a registered busy count.
module reg_file_sb_cell #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic          i_set,
  input  logic [DW-1:0] i_dat,
  output logic [DW-1:0] o_dat,
  output logic          o_busy,
  output logic          o_busy_nxt
);
  logic [DW-1:0] r_dat;
  logic          r_busy;

  // A same-edge issue is the newer producer, so it wins over the writeback clear.
  assign o_busy_nxt = i_set | (r_busy & ~i_we);
  assign o_dat      = r_dat;
  assign o_busy     = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dat  <= '0;
      r_busy <= 1'b0;
    end else begin
      if (i_we) r_dat <= i_dat;
      r_busy <= o_busy_nxt;
    end
  end
endmodule

module reg_file_sb #(
  parameter int DW      = 8,
  parameter int PW      = 4,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_addr,
  input  logic [DW-1:0] dat_in,
  input  logic          iss_en,
  input  logic [PW-1:0] iss_addr,
  input  logic [PW-1:0] rd_addrA,
  input  logic [PW-1:0] rd_addrB,
  output logic [DW-1:0] datA_out,
  output logic [DW-1:0] datB_out,
  output logic          busyA,
  output logic          busyB,
  output logic [PW:0]   busy_cnt
);
  localparam int DEPTH = 1 << PW;
  localparam int NRD   = 2;

  logic [DEPTH-1:0][DW-1:0] w_core;
  logic [DEPTH-1:0]         w_busy;
  logic [DEPTH-1:0]         w_busy_nxt;
  logic [DEPTH-1:0]         w_we;
  logic [DEPTH-1:0]         w_set;
  logic [PW:0]              w_cnt_nxt;
  logic [PW:0]              r_cnt;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_reg
      // r0 in hard-zero mode never takes data and never becomes busy.
      localparam bit LIVE = !(ZERO_R0 && (i == 0));
      assign w_we[i]  = LIVE && wr_en  && (wr_addr  == PW'(i));
      assign w_set[i] = LIVE && iss_en && (iss_addr == PW'(i));
      reg_file_sb_cell #(.DW(DW)) u_cell (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_we[i]),
        .i_set     (w_set[i]),
        .i_dat     (dat_in),
        .o_dat     (w_core[i]),
        .o_busy    (w_busy[i]),
        .o_busy_nxt(w_busy_nxt[i])
      );
    end
  endgenerate

  logic [NRD-1:0][PW-1:0] w_rd_addr;
  logic [NRD-1:0][DW-1:0] w_rd_dat;
  logic [NRD-1:0]         w_rd_busy;

  assign w_rd_addr = {rd_addrB, rd_addrA};

  genvar p;
  generate
    for (p = 0; p < NRD; p++) begin : g_rd
      logic w_hit, w_iss, w_zero;
      assign w_hit  = wr_en  && (wr_addr  == w_rd_addr[p]);
      assign w_iss  = iss_en && (iss_addr == w_rd_addr[p]);
      assign w_zero = ZERO_R0 && (w_rd_addr[p] == '0);
      assign w_rd_dat[p]  = w_zero ? '0 : (w_hit ? dat_in : w_core[w_rd_addr[p]]);
      // The bypass resolves the dependency unless a same-address issue re-arms it.
      assign w_rd_busy[p] = w_busy[w_rd_addr[p]] & ~(w_hit & ~w_iss);
    end
  endgenerate

  assign datA_out = w_rd_dat[0];
  assign datB_out = w_rd_dat[1];
  assign busyA    = w_rd_busy[0];
  assign busyB    = w_rd_busy[1];

  always_comb begin
    w_cnt_nxt = '0;
    for (int k = 0; k < DEPTH; k++)
      w_cnt_nxt = w_cnt_nxt + {{PW{1'b0}}, w_busy_nxt[k]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= w_cnt_nxt;
  end

  assign busy_cnt = r_cnt;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: the normal instance and a hard-zero-r0 instance share the same stimulus.
module tb_reg_file_sb;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, iss_en;
  logic [3:0] wr_addr, iss_addr, rd_addrA, rd_addrB;
  logic [7:0] dat_in;
  logic [7:0] datA0, datB0, datA1, datB1;
  logic       busyA0, busyB0, busyA1, busyB1;
  logic [4:0] cnt0, cnt1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.DW(8), .PW(4), .ZERO_R0(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
    .iss_en(iss_en), .iss_addr(iss_addr), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .datA_out(datA0), .datB_out(datB0), .busyA(busyA0), .busyB(busyB0), .busy_cnt(cnt0));

  reg_file_sb #(.DW(8), .PW(4), .ZERO_R0(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
    .iss_en(iss_en), .iss_addr(iss_addr), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .datA_out(datA1), .datB_out(datB1), .busyA(busyA1), .busyB(busyB1), .busy_cnt(cnt1));

  typedef struct {
    logic       wr;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       iss;
    logic [3:0] ia;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [7:0] eda;
    logic [7:0] edb;
    logic       eba;
    logic       ebb;
    logic [4:0] ecnt;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [3:0] wa, input logic [7:0] wd,
                       input logic s, input logic [3:0] ia, input logic [3:0] ra, input logic [3:0] rb);
    wr_en = w; wr_addr = wa; dat_in = wd; iss_en = s; iss_addr = ia; rd_addrA = ra; rd_addrB = rb;
  endtask

  initial begin
    // Vectors are driven after a negedge and sampled 2ns later, before the next rising edge.
    //          wr  wa  wd     iss ia  ra  rb  datA   datB   bA bB cnt
    vecs[0]  = '{1, 3, 8'hA5, 0, 0, 3, 4, 8'hA5, 8'h00, 0, 0, 0};
    vecs[1]  = '{0, 0, 8'h00, 0, 0, 3, 3, 8'hA5, 8'hA5, 0, 0, 0};
    vecs[2]  = '{0, 0, 8'h00, 1, 5, 5, 3, 8'h00, 8'hA5, 0, 0, 0};
    vecs[3]  = '{0, 0, 8'h00, 0, 0, 3, 5, 8'hA5, 8'h00, 0, 1, 1};
    vecs[4]  = '{1, 5, 8'h3C, 0, 0, 5, 5, 8'h3C, 8'h3C, 0, 0, 1};
    vecs[5]  = '{0, 0, 8'h00, 0, 0, 5, 5, 8'h3C, 8'h3C, 0, 0, 0};
    vecs[6]  = '{1, 7, 8'h11, 1, 7, 7, 7, 8'h11, 8'h11, 0, 0, 0};
    vecs[7]  = '{0, 0, 8'h00, 0, 0, 7, 5, 8'h11, 8'h3C, 1, 0, 1};
    vecs[8]  = '{1, 7, 8'h22, 1, 7, 7, 7, 8'h22, 8'h22, 1, 1, 1};
    vecs[9]  = '{0, 0, 8'h00, 1, 7, 7, 7, 8'h22, 8'h22, 1, 1, 1};
    vecs[10] = '{0, 0, 8'h00, 0, 0, 7, 7, 8'h22, 8'h22, 1, 1, 1};
    vecs[11] = '{1, 7, 8'h44, 1, 9, 7, 9, 8'h44, 8'h00, 0, 0, 1};
    vecs[12] = '{0, 0, 8'h00, 0, 0, 7, 9, 8'h44, 8'h00, 0, 1, 1};
    vecs[13] = '{1, 9, 8'h55, 0, 0, 9, 9, 8'h55, 8'h55, 0, 0, 1};
    vecs[14] = '{0, 0, 8'h00, 0, 0, 9, 3, 8'h55, 8'hA5, 0, 0, 0};
    vecs[15] = '{1, 4, 8'h66, 0, 0, 4, 4, 8'h66, 8'h66, 0, 0, 0};
    vecs[16] = '{0, 0, 8'h00, 0, 0, 4, 15, 8'h66, 8'h00, 0, 0, 0};

    rst_n = 1'b0;
    drive(1, 6, 8'h5A, 1, 6, 0, 15);
    repeat (2) @(negedge clk);
    check("rst_cnt0", cnt0, 0);
    check("rst_cnt1", cnt1, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) begin
      drive(0, 0, 0, 0, 0, 4'(a), 4'(15 - a));
      #1;
      check("rst_datA", datA0, 0);
      check("rst_datB", datB0, 0);
      check("rst_busy", {busyA0, busyB0, busyA1, busyB1}, 0);
    end
    check("rst_cnt_post", cnt0, 0);

    for (int v = 0; v < 17; v++) begin
      @(negedge clk);
      drive(vecs[v].wr, vecs[v].wa, vecs[v].wd, vecs[v].iss, vecs[v].ia, vecs[v].ra, vecs[v].rb);
      #2;
      check($sformatf("v%0d_datA", v), datA0, vecs[v].eda);
      check($sformatf("v%0d_datB", v), datB0, vecs[v].edb);
      check($sformatf("v%0d_busyA", v), busyA0, vecs[v].eba);
      check($sformatf("v%0d_busyB", v), busyB0, vecs[v].ebb);
      check($sformatf("v%0d_cnt", v), cnt0, vecs[v].ecnt);
      check($sformatf("v%0d_z_datA", v), datA1, vecs[v].eda);
      check($sformatf("v%0d_z_cnt", v), cnt1, vecs[v].ecnt);
    end

    // Hard-zero r0: write and issue r0 at the same time.
    @(negedge clk);
    drive(1, 0, 8'hFF, 1, 0, 0, 0);
    #2;
    check("z_bypass_dat0", datA0, 8'hFF);
    check("z_bypass_dat1", datA1, 0);
    check("z_bypass_busy1", busyA1, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    check("z_after_dat0", datA0, 8'hFF);
    check("z_after_busy0", busyA0, 1);
    check("z_after_cnt0", cnt0, 1);
    check("z_after_dat1", datA1, 0);
    check("z_after_busy1", busyA1, 0);
    check("z_after_cnt1", cnt1, 0);

    // Issue every register, then reset between edges with a write in flight.
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      drive(0, 0, 0, 1, 4'(a), 0, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 8, 0);
    #2;
    check("full_cnt0", cnt0, 16);
    check("full_cnt1", cnt1, 15);
    drive(1, 8, 8'h77, 1, 3, 8, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_cnt0", cnt0, 0);
    check("async_cnt1", cnt1, 0);
    check("async_bypass", datA0, 8'h77);
    check("async_busyA", busyA0, 0);
    @(posedge clk);
    @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      drive(0, 0, 0, 0, 0, 4'(a), 4'(a));
      #1;
      check("inrst_dat", datA0, 0);
      check("inrst_busy", {busyA0, busyB0}, 0);
    end
    check("inrst_cnt", cnt0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 2, 8'h99, 1, 6, 2, 8);
    #2;
    check("rel_bypass", datA0, 8'h99);
    check("rel_no_stale", datB0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 2, 6);
    #2;
    check("rel_write", datA0, 8'h99);
    check("rel_busy6", busyB0, 1);
    check("rel_cnt", cnt0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
